pc_branch_ctrl: RTL

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

---
 rtl/pc_branch_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_branch_ctrl.sv
// Fetch PC sequencer with branch/jump decode, stall-pending redirect, exception override and link write.
// Optional branch outcome counters are enabled by defining BRANCH_STATS_EN.
module pc_branch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        br_valid_d,
   input  logic [5:0]  op_d,
   input  logic [4:0]  rt_d,
   input  logic [4:0]  rd_d,
   input  logic [5:0]  funct_d,
   input  logic        take_d,
   input  logic [31:0] pc_plus4_d,
   input  logic [15:0] imm_d,
   input  logic [25:0] instr_index_d,
   input  logic [31:0] rs_val_d,
   input  logic        exc_valid,
   input  logic [31:0] exc_vector,
   output logic [31:0] pc_f,
   output logic        redirect,
   output logic        in_delay_slot_f,
   output logic        link_we,
   output logic [4:0]  link_addr,
   output logic [31:0] link_val,
`ifdef BRANCH_STATS_EN
   output logic [31:0] taken_cnt,
   output logic [31:0] nottaken_cnt,
`endif
   output logic        addr_err
);

   typedef enum logic [0:0] {ST_RUN, ST_PEND} state_e;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

   state_e      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        redirect_q, redirect_d;
   logic        ds_q, ds_d;
   logic        link_we_q, link_we_d;
   logic [4:0]  link_addr_q, link_addr_d;
   logic [31:0] link_val_q, link_val_d;
   logic        addr_err_q, addr_err_d;

   logic        is_cond, is_uncond, is_link31, is_jr_class, is_jalr;
   logic        accept, xfer, taken;
   logic [31:0] target;

   always_comb begin
      is_cond     = 1'b0;
      is_uncond   = 1'b0;
      is_link31   = 1'b0;
      is_jr_class = 1'b0;
      is_jalr     = 1'b0;
      target      = pc_plus4_d + {{14{imm_d[15]}}, imm_d, 2'b00};
      case (op_d)
         6'b000100, 6'b000101, 6'b000110, 6'b000111: is_cond = 1'b1;
         6'b000001: begin
            case (rt_d)
               5'b00000, 5'b00001: is_cond = 1'b1;
               5'b10000, 5'b10001: begin
                  is_cond   = 1'b1;
                  is_link31 = 1'b1;
               end
               default: ;
            endcase
         end
         6'b000010, 6'b000011: begin
            is_uncond = 1'b1;
            is_link31 = op_d[0];
            target    = {pc_plus4_d[31:28], instr_index_d, 2'b00};
         end
         6'b000000: begin
            if (funct_d == 6'b001000 || funct_d == 6'b001001) begin
               is_uncond   = 1'b1;
               is_jr_class = 1'b1;
               is_jalr     = funct_d[0];
               target      = rs_val_d;
            end
         end
         default: ;
      endcase
   end

   // Decode is only honoured in RUN and never alongside an exception.
   assign accept = br_valid_d && (state_q == ST_RUN) && !exc_valid;
   assign xfer   = accept && (is_cond || is_uncond);
   assign taken  = xfer && (is_uncond || take_d);

   always_comb begin
      state_d    = state_q;
      pc_f_d     = pc_f_q;
      pend_pc_d  = pend_pc_q;
      redirect_d = 1'b0;
      if (exc_valid) begin
         pc_f_d     = exc_vector;
         pend_pc_d  = '0;
         redirect_d = 1'b1;
         state_d    = ST_RUN;
      end else if (state_q == ST_PEND) begin
         if (!stall_f) begin
            pc_f_d     = pend_pc_q;
            redirect_d = 1'b1;
            state_d    = ST_RUN;
         end
      end else if (taken) begin
         if (stall_f) begin
            pend_pc_d = target;
            state_d   = ST_PEND;
         end else begin
            pc_f_d     = target;
            redirect_d = 1'b1;
         end
      end else if (!stall_f) begin
         pc_f_d = pc_f_q + 32'd4;
      end

      // Delay-slot flag clears once fetch moves on from where it stood.
      if (exc_valid)
         ds_d = 1'b0;
      else if (xfer)
         ds_d = 1'b1;
      else if (pc_f_d != pc_f_q)
         ds_d = 1'b0;
      else
         ds_d = ds_q;

      link_we_d   = accept && (is_link31 || is_jalr);
      link_addr_d = link_addr_q;
      link_val_d  = link_val_q;
      if (link_we_d) begin
         link_addr_d = is_jalr ? rd_d : 5'd31;
         link_val_d  = pc_plus4_d + 32'd4;
      end
      addr_err_d = accept && is_jr_class && (rs_val_d[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         pc_f_q      <= RESET_PC;
         pend_pc_q   <= '0;
         redirect_q  <= 1'b0;
         ds_q        <= 1'b0;
         link_we_q   <= 1'b0;
         link_addr_q <= '0;
         link_val_q  <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_f_q      <= pc_f_d;
         pend_pc_q   <= pend_pc_d;
         redirect_q  <= redirect_d;
         ds_q        <= ds_d;
         link_we_q   <= link_we_d;
         link_addr_q <= link_addr_d;
         link_val_q  <= link_val_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign pc_f            = pc_f_q;
   assign redirect        = redirect_q;
   assign in_delay_slot_f = ds_q;
   assign link_we         = link_we_q;
   assign link_addr       = link_addr_q;
   assign link_val        = link_val_q;
   assign addr_err        = addr_err_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] taken_cnt_q, taken_cnt_d;
   logic [31:0] nottaken_cnt_q, nottaken_cnt_d;

   always_comb begin
      taken_cnt_d    = taken_cnt_q;
      nottaken_cnt_d = nottaken_cnt_q;
      if (accept && is_cond) begin
         if (take_d)
            taken_cnt_d = taken_cnt_q + 32'd1;
         else
            nottaken_cnt_d = nottaken_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt_q    <= '0;
         nottaken_cnt_q <= '0;
      end else begin
         taken_cnt_q    <= taken_cnt_d;
         nottaken_cnt_q <= nottaken_cnt_d;
      end
   end

   assign taken_cnt    = taken_cnt_q;
   assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule
